tt_scanner: RTL
===============

# tt_scanner

Sequential truth-table scanner for a 4-input combinational function under test, such as the PoS/SoP minterm blocks of the preparation exercises. It steps the 4-bit input index 0..15 into the function's inputs A,B,C,D, waits a settle interval, and captures the function output S into a 16-bit table. After capture it compares the table bit by bit with an expected mask and reports the result. It replaces the hand-written `#1` stimulus sequences with a synthesizable, self-checking stage.

## Interface
- `EXP_MASK`, default 16'h1894, expected S per index; bit i = S for index i (16'h1894 = ones at 2,4,7,11,12).
- `SETTLE`, default 1, DRIVE cycles per index before sampling; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `s_in`  in  1  output S of the function under test.
- `abcd`  out  4  drive to the function; bit3=A, bit2=B, bit1=C, bit0=D.
- `busy`  out  1  high in DRIVE and SAMPLE.
- `done`  out  1  one-cycle pulse when a scan completes.
- `tt`  out  16  captured table; bit i = s_in sampled at index i.
- `mismatch`  out  1  high when any captured bit differs from EXP_MASK.
- `err_idx`  out  4  lowest index that mismatched; 0 when none.
- `err_cnt`  out  5  number of mismatching indices, 0..16.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE. Reset state is IDLE.
- IDLE: when `start`=1, go to DRIVE. On the same edge, clear idx, `tt`, `mismatch`, `err_idx`, and `err_cnt`, and load the settle counter with SETTLE-1.
- DRIVE: `abcd`=idx. Decrement the settle counter each cycle. Go to SAMPLE when it is 0.
- SAMPLE, for index idx:
  - Register `tt[idx]`<=`s_in`.
  - If `s_in`!=EXP_MASK[idx]: increment `err_cnt` and set `mismatch`. If this is the first mismatch of the scan, set `err_idx`<=idx.
  - If idx=15, go to DONE.
  - Otherwise idx<=idx+1, reload the settle counter, and go to DRIVE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored in DRIVE, SAMPLE and DONE. It has no queueing effect.
- Results hold from the DONE cycle until the next accepted `start`.
- `abcd` holds 4'hF after a scan until the next start. idx does not wrap past 15.
- Width rules:
  - `err_cnt` is 5 bits, so 16 mismatches read 5'd16.
  - idx is 4 bits and is only incremented when below 15.
- Reset values: `abcd`=0, `busy`=0, `done`=0, `tt`=16'h0000, `mismatch`=0, `err_idx`=0, `err_cnt`=0.
- Reset asserted mid-scan: all outputs return to reset values immediately (asynchronous), the FSM goes to IDLE, and no `done` pulse is produced.

## Timing
- Edge E0 samples `start`=1. From E0, `busy`=1 and `abcd`=0.
- Each index occupies SETTLE+1 cycles: SETTLE cycles in DRIVE, 1 in SAMPLE.
- `s_in` is sampled at the edge that ends SAMPLE, which gives the function at least SETTLE full cycles to settle.
- The last capture happens at edge E(16·(SETTLE+1)).
- `done`=1 and `busy`=0 for the following cycle. With SETTLE=1, `done` is high between E32 and E33.
- `tt`, `mismatch`, `err_idx`, and `err_cnt` update at SAMPLE edges and are final when `done` rises.
- All outputs are registered. There is no combinational path from `s_in` or `start` to any output.

## Configuration
- `TT_SCANNER_ABORT_EN`:
  - Defined: adds input `abort` (1 bit). `abort`=1 in DRIVE or SAMPLE sends the FSM to IDLE at the next edge with `busy`=0. No `done` pulse is produced. Partial `tt`, `err_cnt`, and `err_idx` are held. `abort` is ignored in IDLE and DONE. If `abort` and the final SAMPLE coincide, `abort` wins and there is no capture of index 15.
  - Undefined: no `abort` port. Every accepted start runs to completion unless reset.

## Test plan
- Connect the PoS function (ones at 2,4,7,11,12), SETTLE=1, pulse `start` -> `done` at E32→E33; `tt`=16'h1894, `mismatch`=0, `err_cnt`=0, `err_idx`=0.
- Tie `s_in`=0 -> `tt`=16'h0000, `mismatch`=1, `err_cnt`=5, `err_idx`=2.
- Drive `s_in`=~S (inverted function) -> `tt`=16'hE76B, `err_cnt`=16, `err_idx`=0.
- SETTLE=3, correct function -> `done` high in the cycle after E64; `abcd` holds each index for 4 cycles; `tt`=16'h1894.
- `start` pulsed again at E10 of a scan, then `rst_n` dropped at E20 -> the second start has no effect; at reset all outputs clear asynchronously, no `done`, FSM in IDLE; a new start then completes normally.
- With `TT_SCANNER_ABORT_EN`, `abort`=1 at E9 (SETTLE=1) -> `busy`=0 after E10, no `done`, `tt[3:0]` hold the indices 0..3 captured at E2, E4, E6 and E8.

Source files
------------

// File: rtl/tt_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tt_scanner
//  Description : Sequential truth-table scanner for a 4-input combinational
//                function. Steps index 0..15 onto abcd, waits SETTLE cycles,
//                captures s_in into a 16-bit table and compares it with
//                EXP_MASK, reporting mismatch flag, first failing index and
//                mismatch count.
//  Optional    : `define TT_SCANNER_ABORT_EN adds an 'abort' input that
//                cancels a running scan (partial results held, no done).
//  Ports       :
//      clk       in   1   clock, rising edge
//      rst_n     in   1   asynchronous active-low reset
//      start     in   1   begin a scan (sampled only in IDLE)
//      abort     in   1   cancel scan (only with TT_SCANNER_ABORT_EN)
//      s_in      in   1   output S of the function under test
//      abcd      out  4   function inputs, bit3=A .. bit0=D
//      busy      out  1   high while driving/sampling
//      done      out  1   one-cycle pulse at scan completion
//      tt        out  16  captured table, bit i = S at index i
//      mismatch  out  1   any captured bit differs from EXP_MASK
//      err_idx   out  4   lowest mismatching index (0 when none)
//      err_cnt   out  5   number of mismatching indices
//  Parameters  : EXP_MASK (expected table), SETTLE (1..15 drive cycles)
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_scanner #(
    parameter logic [15:0] EXP_MASK = 16'h1894,
    parameter int unsigned SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef TT_SCANNER_ABORT_EN
    input  logic        abort,
`endif
    input  logic        s_in,
    output logic [3:0]  abcd,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        mismatch,
    output logic [3:0]  err_idx,
    output logic [4:0]  err_cnt
);

    // SETTLE is legal in 1..15, so the reload value always fits in 4 bits.
    localparam logic [3:0] c_settle_load = 4'(SETTLE - 1);
    localparam logic [3:0] c_last_idx    = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_settle;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_tt;
    logic        r_mismatch;
    logic [3:0]  r_err_idx;
    logic [4:0]  r_err_cnt;

    logic        w_abort;
    logic        w_bit_err;

`ifdef TT_SCANNER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_bit_err = s_in ^ EXP_MASK[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 4'd0;
            r_settle   <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tt       <= 16'h0000;
            r_mismatch <= 1'b0;
            r_err_idx  <= 4'd0;
            r_err_cnt  <= 5'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_DRIVE;
                        r_idx      <= 4'd0;
                        r_settle   <= c_settle_load;
                        r_busy     <= 1'b1;
                        r_tt       <= 16'h0000;
                        r_mismatch <= 1'b0;
                        r_err_idx  <= 4'd0;
                        r_err_cnt  <= 5'd0;
                    end
                end

                S_DRIVE: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_settle == 4'd0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end

                S_SAMPLE: begin
                    // An abort on the final sample wins: index 15 is not captured.
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tt[r_idx] <= s_in;
                        if (w_bit_err) begin
                            r_err_cnt  <= r_err_cnt + 5'd1;
                            r_mismatch <= 1'b1;
                            // mismatch still low means this is the first failing index
                            if (!r_mismatch) begin
                                r_err_idx <= r_idx;
                            end
                        end
                        if (r_idx == c_last_idx) begin
                            // idx stays at 15, so abcd keeps 4'hF until the next start
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx    <= r_idx + 4'd1;
                            r_settle <= c_settle_load;
                            r_state  <= S_DRIVE;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign abcd     = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign tt       = r_tt;
    assign mismatch = r_mismatch;
    assign err_idx  = r_err_idx;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire
